// File: rtl/send_burst_arbiter_pkg.sv
// Shared types and helpers for the send burst arbiter.
package send_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/send_burst_arbiter_if.sv
// Bus between the per-dataflow senders and the shared pixel/header FIFOs.
interface send_burst_arbiter_if #(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int BUFF_SIZE_BIT = 6
);
  logic [N_REQ-1:0]               req;
  logic [N_REQ*BUFF_SIZE_BIT-1:0] buff_size;
  logic [N_REQ*DATA_W-1:0]        px_in;
  logic                           px_full;
  logic                           hdr_full;
  logic                           px_wr;
  logic [DATA_W-1:0]              px_out;
  logic                           hdr_wr;
  logic [BUFF_SIZE_BIT-1:0]       hdr_size;
  logic [N_REQ-1:0]               px_ack;
  logic [N_REQ-1:0]               done;
  logic [N_REQ-1:0]               grant;
  logic                           busy;

  modport master (
    output req, buff_size, px_in, px_full, hdr_full,
    input  px_wr, px_out, hdr_wr, hdr_size, px_ack, done, grant, busy
  );

  modport slave (
    input  req, buff_size, px_in, px_full, hdr_full,
    output px_wr, px_out, hdr_wr, hdr_size, px_ack, done, grant, busy
  );
endinterface

// File: rtl/send_burst_arbiter_counter.sv
// Beat counter with enable and synchronous restart (restart wins).
module send_arb_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_restart,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (i_restart) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/send_burst_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted request at or after i_ptr, wrapping.
module send_arb_rr_pick
  import send_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/send_burst_arbiter.sv
// Grants whole bursts of one sender at a time onto the shared pixel/header FIFOs.
// Define SEND_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module send_burst_arbiter
  import send_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  send_burst_arbiter_if.slave  bus
);

  localparam int IW  = idx_w(N_REQ);
  localparam int BSB = BUFF_SIZE_BIT;

  state_e             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [IW-1:0]      r_gidx;
  logic [BSB-1:0]     r_size;

  logic [BSB-1:0]     w_cnt;
  logic [IW-1:0]      w_ptr;
  logic [N_REQ-1:0]   w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic [BSB-1:0]     w_win_size;
  logic               w_beat;
  logic               w_last;
  logic               w_zero;

  logic [BSB-1:0]     w_size [N_REQ];
  logic [DATA_W-1:0]  w_px   [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_size[g] = bus.buff_size[slice_lo(g, BSB) +: BSB];
    assign w_px[g]   = bus.px_in[slice_lo(g, DATA_W) +: DATA_W];
  end

  send_arb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req (bus.req),
    .i_ptr (w_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  send_arb_counter #(.W(BSB)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_beat),
    .i_restart (w_last),
    .o_cnt     (w_cnt)
  );

  assign w_win_size = w_size[w_pick_idx];

  // The header may only hold off the first beat; later beats wait on the pixel FIFO alone.
  assign w_beat = (r_state == SEND) & ~bus.px_full & ((w_cnt != '0) | ~bus.hdr_full);
  assign w_last = w_beat & (w_cnt == r_size - BSB'(1));
  // Zero-length winner completes straight from IDLE; gated so reset shows no pulse.
  assign w_zero = rst_n & (r_state == IDLE) & w_pick_any & (w_win_size == '0);

`ifdef SEND_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= '0;
    else if (w_zero) r_ptr <= IW'(wrap_inc(32'(w_pick_idx), N_REQ));
    else if (w_last) r_ptr <= IW'(wrap_inc(32'(r_gidx), N_REQ));
  end

  assign w_ptr = r_ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_size  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any && (w_win_size != '0)) begin
            r_state <= SEND;
            r_gnt   <= w_pick_gnt;
            r_gidx  <= w_pick_idx;
            r_size  <= w_win_size;
          end
        end
        SEND: begin
          if (w_last) begin
            r_state <= IDLE;
            r_gnt   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.grant    = r_gnt;
  assign bus.busy     = (r_state == SEND);
  assign bus.hdr_size = r_size;
  assign bus.px_wr    = w_beat;
  assign bus.hdr_wr   = w_beat & (w_cnt == '0);
  assign bus.px_ack   = w_beat ? r_gnt : '0;
  assign bus.done     = w_last ? r_gnt : (w_zero ? w_pick_gnt : '0);
  assign bus.px_out   = (r_gnt != '0) ? w_px[r_gidx] : '0;

endmodule
